// File: rtl/fifo_bist_pkg.sv
// Shared definitions for the DRAM FIFO BIST generator and checker:
// error codes, checker states and CVITA header field layout.
package fifo_bist_pkg;

    localparam logic [1:0] BIST_ERR_NONE    = 2'b00;
    localparam logic [1:0] BIST_ERR_DATA    = 2'b01;
    localparam logic [1:0] BIST_ERR_FRAME   = 2'b10;
    localparam logic [1:0] BIST_ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } bist_state_e;

    localparam int HDR_BYTES   = 8;
    localparam int HDR_SEQ_LSB = 48;
    localparam int HDR_SEQ_W   = 12;
    localparam int HDR_LEN_LSB = 32;
    localparam int HDR_LEN_W   = 16;

    // Only flags/seq/length are compared; the SID half is don't-care.
    localparam logic [63:0] HDR_CHECK_MASK = 64'hFFFF_FFFF_0000_0000;

    function automatic logic [HDR_LEN_W-1:0] hdr_len16(input logic [12:0] pkt_len);
        return HDR_LEN_W'(pkt_len) + HDR_LEN_W'(HDR_BYTES);
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Combinational expected-word generator shared by the BIST packet generator
// and checker, so both ends derive header and payload words identically.
module bist_pattern_gen
    import fifo_bist_pkg::*;
(
    input  logic [31:0]          pattern,
    input  logic                 ramp,
    input  logic [12:0]          pkt_len,
    input  logic [HDR_SEQ_W-1:0] pkt_idx,
    input  logic [9:0]           word_idx,
    input  logic                 is_hdr,
    output logic [63:0]          exp_word
);

    always_comb begin
        exp_word = '0;
        if (is_hdr) begin
            exp_word[HDR_SEQ_LSB +: HDR_SEQ_W] = pkt_idx;
            exp_word[HDR_LEN_LSB +: HDR_LEN_W] = hdr_len16(pkt_len);
        end else begin
            exp_word = {pattern, pattern};
            // Ramp adds the word index across the full 64 bits, wrapping mod 2^64.
            if (ramp) begin
                exp_word = exp_word + 64'(word_idx);
            end
        end
    end

endmodule

// File: rtl/axis_fifo_bist_checker.sv
// Receive-side DRAM FIFO BIST checker: regenerates and compares every beat.
// Optional throughput counters: define FIFO_BIST_CHECKER_THROUGHPUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset, waiting for a start rising edge
// ST_HDR     | expecting the CVITA header beat of packet pkt_idx
// ST_PAYLOAD | expecting payload word word_idx of packet pkt_idx
// ST_DONE    | run finished (clean or error), waiting for next start edge
module axis_fifo_bist_checker
    import fifo_bist_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             bus_clk,
    input  logic             bus_rst,
    input  logic             start,
    input  logic             cont,
    input  logic             ramp,
    input  logic [12:0]      pkt_len,
    input  logic [17:0]      num_pkts,
    input  logic [31:0]      pattern,
    input  logic [63:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic             running,
    output logic             done,
    output logic [1:0]       error,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES);

    bist_state_e      state_q, state_d;
    logic             start_q, start_rise;
    logic             cont_r, ramp_r;
    logic [12:0]      pkt_len_r;
    logic [17:0]      num_pkts_r;
    logic [31:0]      pattern_r;
    logic [17:0]      pkt_idx, pkt_idx_inc;
    logic [9:0]       word_idx, last_word_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       error_q, error_d;
    logic             arm, pkt_inc, word_clr, word_inc;
    logic             in_run, accept, tmo_hit, hdr_bad, pay_bad, is_last_word;
    logic [63:0]      exp_word;

    bist_pattern_gen u_pattern_gen (
        .pattern  (pattern_r),
        .ramp     (ramp_r),
        .pkt_len  (pkt_len_r),
        .pkt_idx  (pkt_idx[HDR_SEQ_W-1:0]),
        .word_idx (word_idx),
        .is_hdr   (state_q == ST_HDR),
        .exp_word (exp_word)
    );

    assign start_rise    = start & ~start_q;
    assign in_run        = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign accept        = i_tvalid & in_run;
    assign pkt_idx_inc   = pkt_idx + 18'd1;
    assign last_word_idx = pkt_len_r[12:3] - 10'd1;
    assign is_last_word  = (word_idx == last_word_idx);
    assign tmo_hit       = (tmo_cnt <= TMO_W'(1)) && !accept;
    assign hdr_bad       = |((i_tdata ^ exp_word) & HDR_CHECK_MASK);
    assign pay_bad       = (i_tdata != exp_word);

    assign i_tready = in_run;
    assign running  = in_run;
    assign done     = (state_q == ST_DONE);
    assign error    = error_q;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        error_d  = error_q;
        arm      = 1'b0;
        pkt_inc  = 1'b0;
        word_clr = 1'b0;
        word_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    arm     = 1'b1;
                    error_d = BIST_ERR_NONE;
                    state_d = (!cont && num_pkts == 18'd0) ? ST_DONE : ST_HDR;
                end
            end
            ST_HDR: begin
                if (cont_r && !start) begin
                    state_d = ST_DONE;
                end else if (accept) begin
                    if (hdr_bad) begin
                        error_d = BIST_ERR_DATA;
                        state_d = ST_DONE;
                    end else if (i_tlast) begin
                        error_d = BIST_ERR_FRAME;
                        state_d = ST_DONE;
                    end else begin
                        word_clr = 1'b1;
                        state_d  = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    error_d = BIST_ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    if (pay_bad) begin
                        error_d = BIST_ERR_DATA;
                        state_d = ST_DONE;
                    end else if (i_tlast != is_last_word) begin
                        error_d = BIST_ERR_FRAME;
                        state_d = ST_DONE;
                    end else if (is_last_word) begin
                        pkt_inc = 1'b1;
                        if ((!cont_r && pkt_idx_inc == num_pkts_r) || (cont_r && !start)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else begin
                        word_inc = 1'b1;
                    end
                end else if (tmo_hit) begin
                    error_d = BIST_ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            start_q    <= 1'b0;
            error_q    <= BIST_ERR_NONE;
            cont_r     <= 1'b0;
            ramp_r     <= 1'b0;
            pkt_len_r  <= '0;
            num_pkts_r <= '0;
            pattern_r  <= '0;
            pkt_idx    <= '0;
            word_idx   <= '0;
            tmo_cnt    <= '0;
        end else begin
            start_q <= start;
            error_q <= error_d;
            if (arm) begin
                cont_r     <= cont;
                ramp_r     <= ramp;
                pkt_len_r  <= pkt_len;
                num_pkts_r <= num_pkts;
                pattern_r  <= pattern;
                pkt_idx    <= '0;
                tmo_cnt    <= TMO_INIT;
            end else if (in_run) begin
                // Idle down-counter: reloaded by every accepted beat.
                if (accept) begin
                    tmo_cnt <= TMO_INIT;
                end else if (tmo_cnt != '0) begin
                    tmo_cnt <= tmo_cnt - TMO_W'(1);
                end
            end
            if (pkt_inc) begin
                pkt_idx <= pkt_idx_inc;
            end
            if (word_clr) begin
                word_idx <= '0;
            end else if (word_inc) begin
                word_idx <= word_idx + 10'd1;
            end
        end
    end

`ifdef FIFO_BIST_CHECKER_THROUGHPUT_EN
    logic [CNT_W-1:0] xfer_q, cyc_q;
    logic             cyc_active;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            xfer_q     <= '0;
            cyc_q      <= '0;
            cyc_active <= 1'b0;
        end else if (arm) begin
            xfer_q     <= '0;
            cyc_q      <= '0;
            cyc_active <= 1'b0;
        end else if (in_run) begin
            if (accept && xfer_q != '1) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
            if (accept) begin
                cyc_active <= 1'b1;
            end
            // Cycle count opens on the first accepted beat of the run.
            if ((accept || cyc_active) && cyc_q != '1) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
        end
    end

    assign xfer_cnt = xfer_q;
    assign cyc_cnt  = cyc_q;
`else
    assign xfer_cnt = '0;
    assign cyc_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_fifo_bist_checker.sv
// Directed self-checking bench for axis_fifo_bist_checker (TIMEOUT_CYCLES=100).
module tb_axis_fifo_bist_checker;

`ifdef FIFO_BIST_CHECKER_THROUGHPUT_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        bus_clk, bus_rst;
    logic        start, cont, ramp;
    logic [12:0] pkt_len;
    logic [17:0] num_pkts;
    logic [31:0] pattern;
    logic [63:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic        running, done;
    logic [1:0]  error;
    logic [31:0] xfer_cnt, cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    axis_fifo_bist_checker #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (32)
    ) dut (
        .bus_clk  (bus_clk),
        .bus_rst  (bus_rst),
        .start    (start),
        .cont     (cont),
        .ramp     (ramp),
        .pkt_len  (pkt_len),
        .num_pkts (num_pkts),
        .pattern  (pattern),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .running  (running),
        .done     (done),
        .error    (error),
        .xfer_cnt (xfer_cnt),
        .cyc_cnt  (cyc_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr_word(input int idx);
        logic [15:0] len16;
        len16 = 16'(pkt_len) + 16'd8;
        return {4'h0, idx[11:0], len16, 32'h5A00_0000 | 32'(idx)};
    endfunction

    function automatic logic [63:0] pay_word(input int w);
        return {pattern, pattern} + (ramp ? 64'(w) : 64'd0);
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic last);
        @(negedge bus_clk);
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        @(posedge bus_clk);
    endtask

    // Sends a whole packet; if flip_word matches, that word gets bit 63
    // inverted and the packet is cut short right after it.
    task automatic send_pkt(input int idx, input int flip_word);
        int nw;
        nw = int'(pkt_len) / 8;
        send_beat(hdr_word(idx), 1'b0);
        for (int w = 0; w < nw; w++) begin
            if (w == flip_word) begin
                send_beat(pay_word(w) ^ 64'h8000_0000_0000_0000, w == nw - 1);
                return;
            end
            send_beat(pay_word(w), w == nw - 1);
        end
    endtask

    task automatic go_idle();
        @(negedge bus_clk);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic restart();
        @(negedge bus_clk);
        start = 1'b0;
        @(negedge bus_clk);
        start = 1'b1;
    endtask

    initial begin
        bus_rst = 1'b1; start = 1'b0; cont = 1'b0; ramp = 1'b0;
        pkt_len = '0; num_pkts = '0; pattern = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(negedge bus_clk);
        check("rst_tready", i_tready, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_xfer", xfer_cnt, 0);
        bus_rst = 1'b0;

        // Clean constant run: 10 packets x 6 beats.
        pkt_len = 13'd40; num_pkts = 18'd10; pattern = 32'h0123_4567;
        restart();
        @(negedge bus_clk);
        check("t1_running_rise", running, 1);
        for (int p = 0; p < 10; p++) send_pkt(p, -1);
        go_idle();
        check("t1_done", done, 1);
        check("t1_running_fall", running, 0);
        check("t1_error", error, 0);
        check("t1_tready", i_tready, 0);
        check("t1_xfer", xfer_cnt, TP ? 60 : 0);
        check("t1_cyc", cyc_cnt, TP ? 60 : 0);
        @(negedge bus_clk);
        start = 1'b0;
        @(negedge bus_clk);
        check("t1_done_hold", done, 1);

        // Bit 63 flipped on payload word 2 of packet 3.
        restart();
        for (int p = 0; p < 3; p++) send_pkt(p, -1);
        send_pkt(3, 2);
        go_idle();
        check("t2_error", error, 1);
        check("t2_done", done, 1);
        check("t2_tready", i_tready, 0);
        check("t2_xfer", xfer_cnt, TP ? 22 : 0);

        // Ramp, 16-byte packet, tlast on word 0.
        pkt_len = 13'd16; num_pkts = 18'd1; ramp = 1'b1; pattern = 32'h0000_0010;
        restart();
        send_beat(64'h0000_0018_0000_0000, 1'b0);
        send_beat(64'h0000_0010_0000_0010, 1'b1);
        go_idle();
        check("t3_early_tlast", error, 2);
        check("t3_done", done, 1);

        // num_pkts = 0 finishes on the start edge and clears the old error.
        num_pkts = 18'd0;
        restart();
        @(negedge bus_clk);
        check("t4_zero_done", done, 1);
        check("t4_zero_running", running, 0);
        check("t4_zero_error", error, 0);

        // Missing tlast on the final word.
        pkt_len = 13'd8; num_pkts = 18'd1; ramp = 1'b0; pattern = 32'hCAFE_F00D;
        restart();
        send_beat(64'h0000_0010_1234_5678, 1'b0);
        send_beat(64'hCAFE_F00D_CAFE_F00D, 1'b0);
        go_idle();
        check("t5_late_tlast", error, 2);

        // Header with wrong sequence number, then wrong length.
        restart();
        send_beat(64'h0001_0010_0000_0000, 1'b0);
        go_idle();
        check("t6_hdr_seq", error, 1);
        restart();
        send_beat(64'h0000_0011_0000_0000, 1'b0);
        go_idle();
        check("t6_hdr_len", error, 1);
        check("t6_done", done, 1);

        // Ramp wrap: FFFFFFFF_FFFFFFFF + 1 wraps to 0.
        pkt_len = 13'd24; num_pkts = 18'd1; ramp = 1'b1; pattern = 32'hFFFF_FFFF;
        restart();
        send_beat(64'h0000_0020_0000_0000, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_beat(64'h0000_0000_0000_0000, 1'b0);
        send_beat(64'h0000_0000_0000_0001, 1'b1);
        go_idle();
        check("t7_wrap_error", error, 0);
        check("t7_wrap_done", done, 1);

        // Continuous: 50 packets, start dropped inside packet 51.
        pkt_len = 13'd16; num_pkts = 18'd3; cont = 1'b1; ramp = 1'b0; pattern = 32'hA5A5_5A5A;
        restart();
        for (int p = 0; p < 50; p++) send_pkt(p, -1);
        send_beat(hdr_word(50), 1'b0);
        go_idle();
        start = 1'b0;
        send_beat(pay_word(0), 1'b0);
        go_idle();
        check("t8_mid_running", running, 1);
        check("t8_mid_done", done, 0);
        send_beat(pay_word(1), 1'b1);
        go_idle();
        check("t8_done", done, 1);
        check("t8_error", error, 0);
        check("t8_running", running, 0);
        check("t8_xfer", xfer_cnt, TP ? 153 : 0);
        check("t8_cyc", cyc_cnt, TP ? 155 : 0);

        // Timeout: a mid-stall header beat must restart the idle count.
        cont = 1'b0; pkt_len = 13'd8; num_pkts = 18'd2;
        restart();
        repeat (60) @(negedge bus_clk);
        i_tvalid = 1'b1;
        i_tdata  = hdr_word(0);
        i_tlast  = 1'b0;
        @(negedge bus_clk);
        i_tvalid = 1'b0;
        repeat (99) @(negedge bus_clk);
        check("t9_pre_tmo_running", running, 1);
        check("t9_pre_tmo_error", error, 0);
        @(negedge bus_clk);
        check("t9_tmo_error", error, 3);
        check("t9_tmo_done", done, 1);

        // Synchronous reset clears a finished run; start held high re-arms after it.
        bus_rst = 1'b1;
        @(negedge bus_clk);
        check("t10_rst_done", done, 0);
        check("t10_rst_error", error, 0);
        check("t10_rst_running", running, 0);
        bus_rst = 1'b0;
        @(negedge bus_clk);
        check("t10_rearm_running", running, 1);
        bus_rst = 1'b1;
        start = 1'b0;
        @(negedge bus_clk);
        check("t10_midrun_running", running, 0);
        check("t10_midrun_tready", i_tready, 0);
        bus_rst = 1'b0;
        @(negedge bus_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
